mul_div_unit: RTL and testbench

Parametrised multiply/divide unit with private HI/LO registers, sitting beside the ALU in the execute stage. It accepts one operation per start pulse and runs signed/unsigned multiply with a configurable fixed latency. Division is iterative and bit-serial, and multiply-accumulate/subtract operations are supported. An operation in flight can be flushed without corrupting HI/LO. The pipeline stalls on `stall` and reads `hi`/`lo` for MFHI/MFLO.

---
 rtl/mul_div_unit.sv | 209 ++++++++++++++++++++
 tb/tb_mul_div_unit.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/mul_div_unit.sv
// mul_div_unit: multiply/divide unit with private HI/LO for the execute stage.
// Multiply-class ops (MULT/MULTU/MADD*/MSUB*) wait a fixed MUL_LATENCY cycles before commit.
// DIV/DIVU run a bit-serial restoring divide on magnitudes, then a single FIX cycle applies signs.
// HI/LO change only at commit or on MTHI/MTLO, so a flushed op leaves them untouched.
module mul_div_unit #(
    parameter int WIDTH       = 32,
    parameter int MUL_LATENCY = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic             flush,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             stall,
    output logic             done
);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MADD  = 4'd5;
    localparam logic [3:0] OP_MADDU = 4'd6;
    localparam logic [3:0] OP_MSUB  = 4'd7;
    localparam logic [3:0] OP_MSUBU = 4'd8;
    localparam logic [3:0] OP_MTHI  = 4'd9;
    localparam logic [3:0] OP_MTLO  = 4'd10;

    // Counter must hold both WIDTH-1 (divide) and MUL_LATENCY-1 (max 14).
    localparam int CNT_W = ($clog2(WIDTH + 1) > 4) ? $clog2(WIDTH + 1) : 4;

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_FIX
    } state_t;

    // Operation attributes captured at issue.
    typedef struct packed {
        logic mul_sgn;   // signed multiply
        logic acc_add;   // {hi,lo} + product
        logic acc_sub;   // {hi,lo} - product
        logic q_neg;     // quotient must be negated in FIX
        logic r_neg;     // remainder must be negated in FIX
        logic div_zero;  // divisor was zero: commit zeros
    } op_ctl_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    op_ctl_t          ctl;
    logic [WIDTH-1:0] opa;   // multiplicand, or dividend shifting into quotient
    logic [WIDTH-1:0] opb;   // multiplier, or divisor magnitude
    logic [WIDTH-1:0] rem;   // partial remainder

    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] acc_res;
    logic [WIDTH:0]     shifted;
    logic [WIDTH:0]     diff;
    logic [WIDTH-1:0]   q_fin;
    logic [WIDTH-1:0]   r_fin;
    logic               is_mul_op;
    logic               is_long_op;
    logic               a_neg;
    logic               b_neg;
    logic [WIDTH-1:0]   abs_a;
    logic [WIDTH-1:0]   abs_b;

    // Issue-side decode and operand magnitudes for signed divide.
    always_comb begin
        is_mul_op  = (op == OP_MULT) || (op == OP_MULTU) || (op == OP_MADD) ||
                     (op == OP_MADDU) || (op == OP_MSUB) || (op == OP_MSUBU);
        is_long_op = is_mul_op || (op == OP_DIV) || (op == OP_DIVU);
        a_neg      = (op == OP_DIV) && src_a[WIDTH-1];
        b_neg      = (op == OP_DIV) && src_b[WIDTH-1];
        abs_a      = a_neg ? (~src_a + 1'b1) : src_a;
        abs_b      = b_neg ? (~src_b + 1'b1) : src_b;
    end

    // Product and accumulate result from the latched operands.
    always_comb begin
        if (ctl.mul_sgn)
            prod = {{WIDTH{opa[WIDTH-1]}}, opa} * {{WIDTH{opb[WIDTH-1]}}, opb};
        else
            prod = {{WIDTH{1'b0}}, opa} * {{WIDTH{1'b0}}, opb};
        if (ctl.acc_add)
            acc_res = {hi, lo} + prod;
        else if (ctl.acc_sub)
            acc_res = {hi, lo} - prod;
        else
            acc_res = prod;
    end

    // One restoring-division step plus the sign fix-up applied in FIX.
    always_comb begin
        shifted = {rem, opa[WIDTH-1]};
        diff    = shifted - {1'b0, opb};
        q_fin   = ctl.q_neg ? (~opa + 1'b1) : opa;
        r_fin   = ctl.r_neg ? (~rem + 1'b1) : rem;
    end

    // Pipeline hold: in flight, or a long op is being issued right now.
    always_comb begin
        stall = busy | (start & ~flush & is_long_op);
    end

    // Main FSM with registered HI/LO, busy and done.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
            cnt   <= '0;
            ctl   <= '0;
            opa   <= '0;
            opb   <= '0;
            rem   <= '0;
            hi    <= '0;
            lo    <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start && !flush) begin
                        if (is_mul_op) begin
                            opa         <= src_a;
                            opb         <= src_b;
                            ctl         <= '0;
                            ctl.mul_sgn <= (op == OP_MULT) || (op == OP_MADD) || (op == OP_MSUB);
                            ctl.acc_add <= (op == OP_MADD) || (op == OP_MADDU);
                            ctl.acc_sub <= (op == OP_MSUB) || (op == OP_MSUBU);
                            cnt         <= CNT_W'(MUL_LATENCY - 1);
                            busy        <= 1'b1;
                            state       <= S_MUL;
                        end else if ((op == OP_DIV) || (op == OP_DIVU)) begin
                            opa          <= abs_a;
                            opb          <= abs_b;
                            rem          <= '0;
                            ctl          <= '0;
                            ctl.q_neg    <= a_neg ^ b_neg;
                            ctl.r_neg    <= a_neg;
                            ctl.div_zero <= (src_b == '0);
                            cnt          <= CNT_W'(WIDTH - 1);
                            busy         <= 1'b1;
                            // A zero divisor skips the iterations entirely.
                            state        <= (src_b == '0) ? S_FIX : S_DIV;
                        end else if (op == OP_MTHI) begin
                            hi <= src_a;
                        end else if (op == OP_MTLO) begin
                            lo <= src_a;
                        end
                    end
                end
                S_MUL: begin
                    if (flush) begin
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end else if (cnt == '0) begin
                        {hi, lo} <= acc_res;
                        done     <= 1'b1;
                        busy     <= 1'b0;
                        state    <= S_IDLE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                S_DIV: begin
                    if (flush) begin
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end else begin
                        // Keep the trial difference only when it did not borrow.
                        if (!diff[WIDTH])
                            rem <= diff[WIDTH-1:0];
                        else
                            rem <= shifted[WIDTH-1:0];
                        opa <= {opa[WIDTH-2:0], ~diff[WIDTH]};
                        if (cnt == '0)
                            state <= S_FIX;
                        else
                            cnt <= cnt - 1'b1;
                    end
                end
                S_FIX: begin
                    if (flush) begin
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end else begin
                        lo    <= ctl.div_zero ? '0 : q_fin;
                        hi    <= ctl.div_zero ? '0 : r_fin;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mul_div_unit.sv
// tb_mul_div_unit: directed vectors with hand-computed HI/LO, latency and flush/reset behaviour.
module tb_mul_div_unit;

    logic        clk;
    logic        reset;
    logic        start;
    logic [3:0]  op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        flush;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        stall;
    logic        done;

    int checks   = 0;
    int failures = 0;

    mul_div_unit #(.WIDTH(32), .MUL_LATENCY(5)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .src_a (src_a),
        .src_b (src_b),
        .flush (flush),
        .hi    (hi),
        .lo    (lo),
        .busy  (busy),
        .stall (stall),
        .done  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called 1 time unit after an edge; returns 1 time unit after the issuing edge.
    task automatic issue(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
        start = 1'b1;
        op    = o;
        src_a = a;
        src_b = b;
        tick();
        start = 1'b0;
        op    = 4'd0;
    endtask

    // Counts busy cycles from the current cycle and checks the result on the done cycle.
    task automatic wait_done(input string tag, input int exp_busy,
                             input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        int n;
        n = 0;
        while (busy && n < 100) begin
            n++;
            tick();
        end
        chk({tag, "_busy_cycles"}, 64'(n), 64'(exp_busy));
        chk({tag, "_done"}, {63'd0, done}, 64'd1);
        chk({tag, "_hi"}, {32'd0, hi}, {32'd0, exp_hi});
        chk({tag, "_lo"}, {32'd0, lo}, {32'd0, exp_lo});
    endtask

    initial begin
        int dn;
        reset = 1'b0;
        start = 1'b0;
        op    = 4'd0;
        src_a = '0;
        src_b = '0;
        flush = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_hi", {32'd0, hi}, 64'd0);
        chk("rst_lo", {32'd0, lo}, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_done", {63'd0, done}, 64'd0);
        reset = 1'b1;
        tick();

        // MULT -2 * 3, stall seen in the issuing cycle
        start = 1'b1; op = 4'd1; src_a = 32'hFFFFFFFE; src_b = 32'd3;
        #1;
        chk("mult_stall_issue", {63'd0, stall}, 64'd1);
        tick();
        start = 1'b0; op = 4'd0;
        chk("mult_hi_hold", {32'd0, hi}, 64'd0);
        wait_done("mult", 5, 32'hFFFFFFFF, 32'hFFFFFFFA);

        // MULTU issued back-to-back in the done cycle
        issue(4'd2, 32'hFFFFFFFE, 32'd3);
        chk("multu_done_clr", {63'd0, done}, 64'd0);
        wait_done("multu", 5, 32'h00000002, 32'hFFFFFFFA);

        issue(4'd4, 32'd100, 32'd7);
        wait_done("divu", 33, 32'd2, 32'd14);

        issue(4'd3, 32'hFFFFFFF9, 32'd2);
        wait_done("div_neg", 33, 32'hFFFFFFFF, 32'hFFFFFFFD);

        issue(4'd3, 32'h80000000, 32'hFFFFFFFF);
        wait_done("div_ovf", 33, 32'h00000000, 32'h80000000);

        // Divide by zero, then MTLO in the done cycle
        issue(4'd3, 32'd5, 32'd0);
        wait_done("div0", 1, 32'd0, 32'd0);
        issue(4'd10, 32'h1234, 32'd0);
        chk("mtlo_lo", {32'd0, lo}, 64'h1234);
        chk("mtlo_busy", {63'd0, busy}, 64'd0);
        chk("mtlo_done", {63'd0, done}, 64'd0);

        // Accumulate
        issue(4'd9, 32'd0, 32'd0);
        issue(4'd10, 32'hFFFFFFFF, 32'd0);
        chk("mthi_hi", {32'd0, hi}, 64'd0);
        issue(4'd6, 32'd1, 32'd1);
        wait_done("maddu", 5, 32'd1, 32'd0);
        issue(4'd7, 32'd1, 32'd2);
        wait_done("msub", 5, 32'd0, 32'hFFFFFFFE);

        // Flush DIVU in busy cycle 10
        issue(4'd4, 32'd100, 32'd7);
        repeat (9) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush_busy", {63'd0, busy}, 64'd0);
        chk("flush_done", {63'd0, done}, 64'd0);
        chk("flush_hi", {32'd0, hi}, 64'd0);
        chk("flush_lo", {32'd0, lo}, 64'hFFFFFFFE);
        dn = 0;
        repeat (40) begin
            if (done) dn++;
            tick();
        end
        chk("flush_no_done", 64'(dn), 64'd0);
        issue(4'd1, 32'd3, 32'd4);
        wait_done("post_flush_mult", 5, 32'd0, 32'd12);

        // Start while busy is ignored
        issue(4'd2, 32'd2, 32'd3);
        start = 1'b1; op = 4'd9; src_a = 32'hAA;
        tick();
        start = 1'b0; op = 4'd0;
        wait_done("ign_start", 4, 32'd0, 32'd6);

        // Flush in IDLE suppresses MTLO
        start = 1'b1; flush = 1'b1; op = 4'd10; src_a = 32'h77;
        #1;
        chk("flush_idle_stall", {63'd0, stall}, 64'd0);
        tick();
        start = 1'b0; flush = 1'b0; op = 4'd0;
        chk("flush_idle_lo", {32'd0, lo}, 64'd6);

        // Reset in busy cycle 3 of a MULT
        issue(4'd1, 32'd5, 32'd5);
        tick();
        tick();
        #1;
        reset = 1'b0;
        #1;
        chk("amid_rst_lo", {32'd0, lo}, 64'd0);
        chk("amid_rst_busy", {63'd0, busy}, 64'd0);
        issue(4'd9, 32'h0, 32'h0);
        chk("amid_rst_hi", {32'd0, hi}, 64'd0);
        chk("amid_rst_done", {63'd0, done}, 64'd0);
        reset = 1'b1;
        tick();
        dn = 0;
        repeat (8) begin
            if (done || busy) dn++;
            tick();
        end
        chk("rst_no_done", 64'(dn), 64'd0);
        issue(4'd2, 32'd7, 32'd6);
        wait_done("post_rst_multu", 5, 32'd0, 32'd42);

        // Flush in the multiply commit cycle wins
        issue(4'd1, 32'd2, 32'd2);
        repeat (4) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush_commit_done", {63'd0, done}, 64'd0);
        chk("flush_commit_lo", {32'd0, lo}, 64'd42);
        chk("flush_commit_busy", {63'd0, busy}, 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
